id_micro_coder: RTL and testbench

ID-stage micro-coder that encodes a raw 32-bit MIPS instruction into the 6-bit micro-instruction type (`INS_*` codes) consumed by the EX-stage micro decoder, plus extracted operand fields.
Registered with valid/ready handshakes on both sides and a one-entry skid buffer, so the upstream ready is a register output.
Sits between the IF/ID fetch queue and the ID/EX dispatch register.
Supports stall (via out_ready) and synchronous flush on branch redirect.

---
 rtl/id_micro_coder_pkg.sv | 134 +++++++++++++
 rtl/id_micro_encode.sv | 113 +++++++++++
 rtl/id_micro_coder.sv | 137 +++++++++++++
 tb/tb_id_micro_coder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_micro_coder_pkg.sv
// Shared MIPS decode constants for the ID micro-coder
// and the EX micro decoder.
package id_micro_coder_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  localparam logic [5:0] INS_NOP   = 6'd0;
  localparam logic [5:0] INS_ADD   = 6'd1;
  localparam logic [5:0] INS_ADDU  = 6'd2;
  localparam logic [5:0] INS_SUB   = 6'd3;
  localparam logic [5:0] INS_SUBU  = 6'd4;
  localparam logic [5:0] INS_AND   = 6'd5;
  localparam logic [5:0] INS_OR    = 6'd6;
  localparam logic [5:0] INS_XOR   = 6'd7;
  localparam logic [5:0] INS_NOR   = 6'd8;
  localparam logic [5:0] INS_SLT   = 6'd9;
  localparam logic [5:0] INS_SLTU  = 6'd10;
  localparam logic [5:0] INS_SLL   = 6'd11;
  localparam logic [5:0] INS_SRL   = 6'd12;
  localparam logic [5:0] INS_SRA   = 6'd13;
  localparam logic [5:0] INS_SLLV  = 6'd14;
  localparam logic [5:0] INS_SRLV  = 6'd15;
  localparam logic [5:0] INS_SRAV  = 6'd16;
  localparam logic [5:0] INS_J     = 6'd17;
  localparam logic [5:0] INS_JAL   = 6'd18;
  localparam logic [5:0] INS_JR    = 6'd19;
  localparam logic [5:0] INS_JALR  = 6'd20;
  localparam logic [5:0] INS_BEQ   = 6'd21;
  localparam logic [5:0] INS_BNE   = 6'd22;
  localparam logic [5:0] INS_BLEZ  = 6'd23;
  localparam logic [5:0] INS_BGTZ  = 6'd24;
  localparam logic [5:0] INS_BLTZ  = 6'd25;
  localparam logic [5:0] INS_BGEZ  = 6'd26;
  localparam logic [5:0] INS_LW    = 6'd27;
  localparam logic [5:0] INS_LB    = 6'd28;
  localparam logic [5:0] INS_LBU   = 6'd29;
  localparam logic [5:0] INS_LH    = 6'd30;
  localparam logic [5:0] INS_LHU   = 6'd31;
  localparam logic [5:0] INS_SW    = 6'd32;
  localparam logic [5:0] INS_SB    = 6'd33;
  localparam logic [5:0] INS_SH    = 6'd34;
  localparam logic [5:0] INS_ADDI  = 6'd35;
  localparam logic [5:0] INS_ADDIU = 6'd36;
  localparam logic [5:0] INS_SLTI  = 6'd37;
  localparam logic [5:0] INS_SLTIU = 6'd38;
  localparam logic [5:0] INS_ANDI  = 6'd39;
  localparam logic [5:0] INS_ORI   = 6'd40;
  localparam logic [5:0] INS_XORI  = 6'd41;
  localparam logic [5:0] INS_LUI   = 6'd42;

  localparam logic [5:0] INS_RCAL_MIN   = INS_ADD;
  localparam logic [5:0] INS_RCAL_MAX   = INS_SLTU;
  localparam logic [5:0] INS_SHIFT_MIN  = INS_SLL;
  localparam logic [5:0] INS_SHIFT_MAX  = INS_SRAV;
  localparam logic [5:0] INS_JUMP_MIN   = INS_J;
  localparam logic [5:0] INS_JUMP_MAX   = INS_JALR;
  localparam logic [5:0] INS_BRANCH_MIN = INS_BEQ;
  localparam logic [5:0] INS_BRANCH_MAX = INS_BGEZ;
  localparam logic [5:0] INS_LOAD_MIN   = INS_LW;
  localparam logic [5:0] INS_LOAD_MAX   = INS_LHU;
  localparam logic [5:0] INS_STORE_MIN  = INS_SW;
  localparam logic [5:0] INS_STORE_MAX  = INS_SH;
  localparam logic [5:0] INS_ICAL_MIN   = INS_ADDI;
  localparam logic [5:0] INS_ICAL_MAX   = INS_LUI;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    DST_NONE, DST_RD, DST_RT,
    DST_LINK, DST_RD_LINK
  } dst_sel_e;

  typedef struct packed {
    logic [5:0]  ins_type;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic        illegal;
  } uop_t;

endpackage

// File: rtl/id_micro_encode.sv
// Combinational MIPS instruction to micro-op type encoder:
// type, write-back register and illegal flag.
module id_micro_encode
  import id_micro_coder_pkg::*;
#(
  parameter int LINK_REG = 31
) (
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] fn,
  output logic [5:0] ins_type,
  output logic [4:0] dst,
  output logic       reg_write,
  output logic       illegal
);

  localparam logic [4:0] LINK = 5'(LINK_REG);

  logic [5:0] ins_sel;
  dst_sel_e   dsel;
  logic       bad;
  logic [4:0] dst_raw;

  // Opcode/funct table lookup
  always_comb begin
    ins_sel = INS_NOP;
    dsel    = DST_NONE;
    bad     = 1'b0;
    unique case (op)
      OP_SPECIAL: begin
        dsel = DST_RD;
        unique case (fn)
          FN_ADD:  ins_sel = INS_ADD;
          FN_ADDU: ins_sel = INS_ADDU;
          FN_SUB:  ins_sel = INS_SUB;
          FN_SUBU: ins_sel = INS_SUBU;
          FN_AND:  ins_sel = INS_AND;
          FN_OR:   ins_sel = INS_OR;
          FN_XOR:  ins_sel = INS_XOR;
          FN_NOR:  ins_sel = INS_NOR;
          FN_SLT:  ins_sel = INS_SLT;
          FN_SLTU: ins_sel = INS_SLTU;
          FN_SLL:  ins_sel = INS_SLL;
          FN_SRL:  ins_sel = INS_SRL;
          FN_SRA:  ins_sel = INS_SRA;
          FN_SLLV: ins_sel = INS_SLLV;
          FN_SRLV: ins_sel = INS_SRLV;
          FN_SRAV: ins_sel = INS_SRAV;
          FN_JR: begin
            ins_sel = INS_JR;
            dsel    = DST_NONE;
          end
          FN_JALR: begin
            ins_sel = INS_JALR;
            dsel    = DST_RD_LINK;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        unique case (rt)
          RT_BLTZ: ins_sel = INS_BLTZ;
          RT_BGEZ: ins_sel = INS_BGEZ;
          default: bad = 1'b1;
        endcase
      end
      OP_J:    ins_sel = INS_J;
      OP_JAL: begin
        ins_sel = INS_JAL;
        dsel    = DST_LINK;
      end
      OP_BEQ:  ins_sel = INS_BEQ;
      OP_BNE:  ins_sel = INS_BNE;
      OP_BLEZ: ins_sel = INS_BLEZ;
      OP_BGTZ: ins_sel = INS_BGTZ;
      OP_LW:   begin ins_sel = INS_LW;  dsel = DST_RT; end
      OP_LB:   begin ins_sel = INS_LB;  dsel = DST_RT; end
      OP_LBU:  begin ins_sel = INS_LBU; dsel = DST_RT; end
      OP_LH:   begin ins_sel = INS_LH;  dsel = DST_RT; end
      OP_LHU:  begin ins_sel = INS_LHU; dsel = DST_RT; end
      OP_SW:   ins_sel = INS_SW;
      OP_SB:   ins_sel = INS_SB;
      OP_SH:   ins_sel = INS_SH;
      OP_ADDI:  begin ins_sel = INS_ADDI;  dsel = DST_RT; end
      OP_ADDIU: begin ins_sel = INS_ADDIU; dsel = DST_RT; end
      OP_SLTI:  begin ins_sel = INS_SLTI;  dsel = DST_RT; end
      OP_SLTIU: begin ins_sel = INS_SLTIU; dsel = DST_RT; end
      OP_ANDI:  begin ins_sel = INS_ANDI;  dsel = DST_RT; end
      OP_ORI:   begin ins_sel = INS_ORI;   dsel = DST_RT; end
      OP_XORI:  begin ins_sel = INS_XORI;  dsel = DST_RT; end
      OP_LUI:   begin ins_sel = INS_LUI;   dsel = DST_RT; end
      default: bad = 1'b1;
    endcase
  end

  // Write-back register select; illegal ops write nothing
  always_comb begin
    dst_raw = '0;
    unique case (dsel)
      DST_RD:      dst_raw = rd;
      DST_RT:      dst_raw = rt;
      DST_LINK:    dst_raw = LINK;
      DST_RD_LINK: dst_raw = (rd == '0) ? LINK : rd;
      default:     dst_raw = '0;
    endcase
    ins_type  = bad ? INS_NOP : ins_sel;
    dst       = bad ? 5'd0 : dst_raw;
    illegal   = bad;
    reg_write = (dst != 5'd0);
  end

endmodule

// File: rtl/id_micro_coder.sv
// ID-stage micro-coder: registered output stage with a
// one-entry skid buffer so in_ready comes from a flop.
module id_micro_coder
  import id_micro_coder_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_ins_type,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_dst,
  output logic            out_reg_write,
  output logic [4:0]      out_shamt,
  output logic [15:0]     out_imm,
  output logic [25:0]     out_jidx,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  uop_t            enc;
  logic [5:0]      enc_type;
  logic [4:0]      enc_dst;
  logic            enc_rw;
  logic            enc_ill;

  uop_t            main_q, main_d;
  uop_t            skid_q, skid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            acc, drain;

  id_micro_encode #(
    .LINK_REG (LINK_REG)
  ) u_enc (
    .op        (in_instr[31:26]),
    .rt        (in_instr[20:16]),
    .rd        (in_instr[15:11]),
    .fn        (in_instr[5:0]),
    .ins_type  (enc_type),
    .dst       (enc_dst),
    .reg_write (enc_rw),
    .illegal   (enc_ill)
  );

  // Assemble the micro-op from the encoder and raw fields
  always_comb begin
    enc           = '0;
    enc.ins_type  = enc_type;
    enc.rs        = in_instr[25:21];
    enc.rt        = in_instr[20:16];
    enc.dst       = enc_dst;
    enc.reg_write = enc_rw;
    enc.shamt     = in_instr[10:6];
    enc.imm       = in_instr[15:0];
    enc.jidx      = in_instr[25:0];
    enc.illegal   = enc_ill;
  end

  assign in_ready = !skid_valid_q;
  assign acc      = in_valid && !skid_valid_q;
  assign drain    = !out_valid_q || out_ready;

  // Handshake control: flush, skid drain, load main or skid
  always_comb begin
    main_d       = main_q;
    main_pc_d    = main_pc_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_d       = skid_q;
        main_pc_d    = skid_pc_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (acc && drain) begin
      main_d      = enc;
      main_pc_d   = in_pc;
      out_valid_d = 1'b1;
    end else if (acc) begin
      skid_d       = enc;
      skid_pc_d    = in_pc;
      skid_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Main and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_pc_q    <= '0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_pc_q    <= main_pc_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_ins_type  = main_q.ins_type;
  assign out_rs        = main_q.rs;
  assign out_rt        = main_q.rt;
  assign out_dst       = main_q.dst;
  assign out_reg_write = main_q.reg_write;
  assign out_shamt     = main_q.shamt;
  assign out_imm       = main_q.imm;
  assign out_jidx      = main_q.jidx;
  assign out_pc        = main_pc_q;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_micro_coder.sv
// Self-checking bench for id_micro_coder: directed steps
// plus a randomized run against a queue-based model.
module tb_id_micro_coder;

  localparam int T_NOP  = 0;
  localparam int T_ADD  = 1;
  localparam int T_SLL  = 11;
  localparam int T_JAL  = 18;
  localparam int T_BEQ  = 21;
  localparam int T_LW   = 27;
  localparam int T_ADDI = 35;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_ins_type;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic        out_reg_write;
  logic [4:0]  out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_jidx;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  int fn_tab [64];
  int op_tab [64];

  logic [101:0] q [$];
  logic [101:0] snap;
  logic         hold_prev = 1'b0;

  logic [5:0] op_list [26] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
    6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
    6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
    6'h28, 6'h29, 6'h2B, 6'h22, 6'h3F};
  logic [5:0] fn_list [21] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
    6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
    6'h06, 6'h07, 6'h08, 6'h09, 6'h01, 6'h05, 6'h3F};

  id_micro_coder #(
    .PC_W     (32),
    .LINK_REG (31)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ins_type  (out_ins_type),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_dst       (out_dst),
    .out_reg_write (out_reg_write),
    .out_shamt     (out_shamt),
    .out_imm       (out_imm),
    .out_jidx      (out_jidx),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_tables();
    for (int i = 0; i < 64; i++) begin
      fn_tab[i] = -1;
      op_tab[i] = -1;
    end
    fn_tab[6'h20] = 1;  fn_tab[6'h21] = 2;
    fn_tab[6'h22] = 3;  fn_tab[6'h23] = 4;
    fn_tab[6'h24] = 5;  fn_tab[6'h25] = 6;
    fn_tab[6'h26] = 7;  fn_tab[6'h27] = 8;
    fn_tab[6'h2A] = 9;  fn_tab[6'h2B] = 10;
    fn_tab[6'h00] = 11; fn_tab[6'h02] = 12;
    fn_tab[6'h03] = 13; fn_tab[6'h04] = 14;
    fn_tab[6'h06] = 15; fn_tab[6'h07] = 16;
    fn_tab[6'h08] = 19; fn_tab[6'h09] = 20;
    op_tab[6'h02] = 17; op_tab[6'h03] = 18;
    op_tab[6'h04] = 21; op_tab[6'h05] = 22;
    op_tab[6'h06] = 23; op_tab[6'h07] = 24;
    op_tab[6'h23] = 27; op_tab[6'h20] = 28;
    op_tab[6'h24] = 29; op_tab[6'h21] = 30;
    op_tab[6'h25] = 31; op_tab[6'h2B] = 32;
    op_tab[6'h28] = 33; op_tab[6'h29] = 34;
    for (int i = 0; i < 8; i++) op_tab[8 + i] = 35 + i;
  endtask

  // Expected micro-op from the instruction-set rules
  function automatic logic [101:0] model(
      input logic [31:0] i, input logic [31:0] pc);
    int         ty;
    logic [4:0] d;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    op = i[31:26];
    fn = i[5:0];
    rt = i[20:16];
    rd = i[15:11];
    d  = 5'd0;
    if (op == 6'd0) begin
      ty = fn_tab[fn];
      if (fn == 6'h08) d = 5'd0;
      else if (fn == 6'h09 && rd == 5'd0) d = 5'd31;
      else d = rd;
    end else if (op == 6'd1) begin
      ty = (rt == 5'd0) ? 25 : (rt == 5'd1) ? 26 : -1;
    end else begin
      ty = op_tab[op];
      if (op == 6'd3) d = 5'd31;
      else if ((ty >= 27 && ty <= 31) || ty >= 35) d = rt;
    end
    if (ty < 0) begin
      return {6'd0, i[25:21], rt, 5'd0, 1'b0, i[10:6],
              i[15:0], i[25:0], pc, 1'b1};
    end
    return {6'(ty), i[25:21], rt, d, (d != 5'd0), i[10:6],
            i[15:0], i[25:0], pc, 1'b0};
  endfunction

  function automatic logic [101:0] pack_out();
    return {out_ins_type, out_rs, out_rt, out_dst,
            out_reg_write, out_shamt, out_imm, out_jidx,
            out_pc, out_illegal};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      w[31:26] = 6'd0;
      w[5:0]   = fn_list[$urandom_range(0, 20)];
    end else if (k < 9) begin
      w[31:26] = op_list[$urandom_range(0, 25)];
    end
    if (w[31:26] == 6'd1) w[20:16] = 5'($urandom_range(0, 2));
    if ($urandom_range(0, 3) == 0) w[15:11] = 5'd0;
    return w;
  endfunction

  // Scoreboard at the falling edge, then advance past posedge
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("occ_valid", out_valid, q.size() > 0);
      chk("occ_ready", in_ready, q.size() < 2);
      if (hold_prev) chk("stall_hold", pack_out(), snap);
      if (out_valid && out_ready && q.size() > 0)
        chk("uop", pack_out(), q.pop_front());
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(in_instr, in_pc));
      hold_prev = out_valid && !out_ready && !flush;
      snap      = pack_out();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w,
                       input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
  endtask

  initial begin
    init_tables();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", pack_out(), 102'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single add
    out_ready = 1'b1;
    offer(32'h00221820, 32'h100);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_type", out_ins_type, T_ADD);
    chk("add_rs", out_rs, 5'd1);
    chk("add_rt", out_rt, 5'd2);
    chk("add_dst", out_dst, 5'd3);
    chk("add_rw", out_reg_write, 1'b1);
    chk("add_pc", out_pc, 32'h100);
    chk("add_ready", in_ready, 1'b1);

    // back-to-back stream
    offer(32'h20220005, 32'h104);
    tick();
    chk("s0_type", out_ins_type, T_ADDI);
    chk("s0_dst", out_dst, 5'd2);
    chk("s0_imm", out_imm, 16'd5);
    offer(32'h8CA40008, 32'h108);
    tick();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_type", out_ins_type, T_LW);
    chk("s1_dst", out_dst, 5'd4);
    chk("s1_rs", out_rs, 5'd5);
    chk("s1_imm", out_imm, 16'd8);
    offer(32'h10220003, 32'h10C);
    tick();
    chk("s2_type", out_ins_type, T_BEQ);
    chk("s2_rw", out_reg_write, 1'b0);
    offer(32'h00031100, 32'h110);
    tick();
    chk("s3_type", out_ins_type, T_SLL);
    chk("s3_dst", out_dst, 5'd2);
    chk("s3_rt", out_rt, 5'd3);
    chk("s3_shamt", out_shamt, 5'd4);
    in_valid = 1'b0;
    tick();
    chk("s_idle", out_valid, 1'b0);

    // stall into skid, then release
    out_ready = 1'b0;
    offer(32'h00221820, 32'h200);
    tick();
    offer(32'h20220005, 32'h204);
    tick();
    chk("stl_ready", in_ready, 1'b0);
    chk("stl_type", out_ins_type, T_ADD);
    in_valid = 1'b0;
    tick();
    chk("stl_hold", out_ins_type, T_ADD);
    chk("stl_ready2", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("rel_type", out_ins_type, T_ADDI);
    chk("rel_pc", out_pc, 32'h204);
    chk("rel_ready", in_ready, 1'b1);
    tick();
    chk("rel_idle", out_valid, 1'b0);

    // flush with skid full and a beat offered
    out_ready = 1'b0;
    offer(32'h00221820, 32'h300);
    tick();
    offer(32'h20220005, 32'h304);
    tick();
    offer(32'h8CA40008, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_gone", out_valid, 1'b0);
    tick();

    // jal and an illegal opcode
    offer(32'h0C000010, 32'h400);
    tick();
    chk("jal_type", out_ins_type, T_JAL);
    chk("jal_dst", out_dst, 5'd31);
    chk("jal_rw", out_reg_write, 1'b1);
    chk("jal_jidx", out_jidx, 26'h10);
    offer(32'hFC000000, 32'h404);
    tick();
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_type", out_ins_type, T_NOP);
    chk("ill_rw", out_reg_write, 1'b0);
    in_valid = 1'b0;
    tick();

    // asynchronous reset during a stall
    out_ready = 1'b0;
    offer(32'h00221820, 32'h500);
    tick();
    offer(32'h20220005, 32'h504);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_ready", in_ready, 1'b1);
    chk("ar_data", pack_out(), 102'd0);
    q.delete();
    hold_prev = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    chk("ar_idle", out_valid, 1'b0);
    chk("ar_zero", pack_out(), 102'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
